// File: rtl/def.sv
// Memory access-mode encodings shared by the caches, data_mem and the port arbiter.
package def_pkg;

  localparam logic [2:0] DATA_ADDR_MODE_B  = 3'b000;
  localparam logic [2:0] DATA_ADDR_MODE_H  = 3'b001;
  localparam logic [2:0] DATA_ADDR_MODE_W  = 3'b010;
  localparam logic [2:0] DATA_ADDR_MODE_BU = 3'b100;
  localparam logic [2:0] DATA_ADDR_MODE_HU = 3'b101;

endpackage

// File: rtl/mem_port_arbiter_pkg.sv
// Types shared by the main-memory port arbiter and its round-robin picker.
package mem_arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} arb_state_t;

  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  typedef struct packed {
    logic                  we;
    logic [2:0]            addr_mode;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and status signals of the shared memory port, bundled for the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  i_ack;

  logic                  d_req;
  logic                  d_we;
  logic [2:0]            d_addr_mode;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_ack;

  logic                  mem_req;
  logic                  mem_we;
  logic [2:0]            mem_addr_mode;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  logic                  err;
  logic                  busy;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr_mode, d_addr, d_wdata, mem_rdata, mem_ack,
    output i_rdata, i_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr_mode, mem_addr,
           mem_wdata, err, busy
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr_mode, d_addr, d_wdata, mem_rdata, mem_ack,
    input  i_rdata, i_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr_mode, mem_addr,
           mem_wdata, err, busy
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on contention the requester not granted last wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  grant_t     last_grant,
  output logic       grant_valid,
  output grant_t     grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = GRANT_I;
    if (req[0] && req[1]) begin
      grant_id = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (req[1]) begin
      grant_id = GRANT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the main-memory port between I-side refills and D-side refills/write-throughs,
// holding each grant until mem_ack or a watchdog timeout.
module mem_port_arbiter
  import def_pkg::*;
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = ARB_ADDR_W,
  parameter int DATA_WIDTH     = ARB_DATA_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  arb_state_t            state_q, state_d;
  grant_t                last_grant_q, last_grant_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [2:0]            mem_addr_mode_q, mem_addr_mode_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  i_ack_q, i_ack_d;
  logic                  d_ack_q, d_ack_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  mem_req_t i_fields, d_fields, sel_fields;
  logic     grant_valid;
  grant_t   grant_id;

  rr_arb2 u_rr_arb2 (
    .req        ({bus.d_req, bus.i_req}),
    .last_grant (last_grant_q),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  // last_grant_q doubles as the owner of the transaction in flight
  always_comb begin
    i_fields   = '{we: 1'b0, addr_mode: DATA_ADDR_MODE_W, addr: bus.i_addr, wdata: '0};
    d_fields   = '{we: bus.d_we, addr_mode: bus.d_addr_mode, addr: bus.d_addr,
                   wdata: bus.d_wdata};
    sel_fields = (grant_id == GRANT_I) ? i_fields : d_fields;

    state_d         = state_q;
    last_grant_d    = last_grant_q;
    cnt_d           = cnt_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_mode_d = mem_addr_mode_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    i_rdata_d       = i_rdata_q;
    d_rdata_d       = d_rdata_q;
    i_ack_d         = 1'b0;
    d_ack_d         = 1'b0;
    err_d           = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          mem_req_d       = 1'b1;
          mem_we_d        = sel_fields.we;
          mem_addr_mode_d = sel_fields.addr_mode;
          mem_addr_d      = sel_fields.addr;
          mem_wdata_d     = sel_fields.wdata;
          last_grant_d    = grant_id;
          cnt_d           = 8'd0;
          state_d         = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // mem_ack wins over a simultaneous watchdog expiry
        if (bus.mem_ack || (cnt_q == TIMEOUT_LAST)) begin
          mem_req_d = 1'b0;
          err_d     = !bus.mem_ack;
          state_d   = RESP;
          if (last_grant_q == GRANT_I) begin
            i_ack_d = 1'b1;
            if (!mem_we_q) i_rdata_d = bus.mem_ack ? bus.mem_rdata : '0;
          end else begin
            d_ack_d = 1'b1;
            if (!mem_we_q) d_rdata_d = bus.mem_ack ? bus.mem_rdata : '0;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      last_grant_q    <= GRANT_D;
      cnt_q           <= 8'd0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_mode_q <= DATA_ADDR_MODE_W;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      i_rdata_q       <= '0;
      d_rdata_q       <= '0;
      i_ack_q         <= 1'b0;
      d_ack_q         <= 1'b0;
      err_q           <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      cnt_q           <= cnt_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_mode_q <= mem_addr_mode_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      i_rdata_q       <= i_rdata_d;
      d_rdata_q       <= d_rdata_d;
      i_ack_q         <= i_ack_d;
      d_ack_q         <= d_ack_d;
      err_q           <= err_d;
      busy_q          <= busy_d;
    end
  end

  assign bus.mem_req       = mem_req_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr_mode = mem_addr_mode_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.i_rdata       = i_rdata_q;
  assign bus.d_rdata       = d_rdata_q;
  assign bus.i_ack         = i_ack_q;
  assign bus.d_ack         = d_ack_q;
  assign bus.err           = err_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single grants, round-robin order, watchdog and reset abort.
module tb_mem_port_arbiter;
  import def_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miscmp;

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_req       = 1'b0;
    bus.i_addr      = '0;
    bus.d_req       = 1'b0;
    bus.d_we        = 1'b0;
    bus.d_addr_mode = DATA_ADDR_MODE_W;
    bus.d_addr      = '0;
    bus.d_wdata     = '0;
    bus.mem_rdata   = '0;
    bus.mem_ack     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic        exp_d [4];
  logic [31:0] rd_val;
  int          cnt;

  initial begin
    n_vec    = 0;
    n_miscmp = 0;
    clear_inputs();
    do_reset();

    // Reset state
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_acks", {bus.i_ack, bus.d_ack, bus.err}, 3'b000);
    chk("rst_mode", bus.mem_addr_mode, DATA_ADDR_MODE_W);
    chk("rst_i_rdata", bus.i_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);

    // I-only read, acked in the first WAIT cycle
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_0040;
    tick();
    chk("i_rd_req", bus.mem_req, 1'b1);
    chk("i_rd_addr", bus.mem_addr, 32'h0000_0040);
    chk("i_rd_we", bus.mem_we, 1'b0);
    chk("i_rd_busy", bus.busy, 1'b1);
    chk("i_rd_early_ack", bus.i_ack, 1'b0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("i_rd_req_drop", bus.mem_req, 1'b0);
    chk("i_rd_ack", {bus.i_ack, bus.d_ack, bus.err}, 3'b100);
    chk("i_rd_data", bus.i_rdata, 32'hDEAD_BEEF);
    bus.mem_ack = 1'b0;
    bus.i_req   = 1'b0;
    tick();
    chk("i_rd_ack_pulse", {bus.i_ack, bus.busy}, 2'b00);

    // Stray mem_ack in IDLE
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1111_2222;
    tick();
    chk("idle_ack_ignored", {bus.i_ack, bus.d_ack, bus.busy, bus.mem_req}, 4'b0000);
    chk("idle_ack_data", bus.i_rdata, 32'hDEAD_BEEF);
    bus.mem_ack = 1'b0;
    tick();

    // D byte write
    bus.d_req       = 1'b1;
    bus.d_we        = 1'b1;
    bus.d_addr_mode = DATA_ADDR_MODE_B;
    bus.d_addr      = 32'h0000_0103;
    bus.d_wdata     = 32'h0000_00AB;
    tick();
    chk("d_wr_req", bus.mem_req, 1'b1);
    chk("d_wr_we", bus.mem_we, 1'b1);
    chk("d_wr_addr", bus.mem_addr, 32'h0000_0103);
    chk("d_wr_mode", bus.mem_addr_mode, DATA_ADDR_MODE_B);
    chk("d_wr_wdata", bus.mem_wdata, 32'h0000_00AB);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    tick();
    chk("d_wr_ack", {bus.i_ack, bus.d_ack, bus.err}, 3'b010);
    chk("d_wr_rdata_kept", bus.d_rdata, 32'h0);
    bus.mem_ack = 1'b0;
    clear_inputs();
    tick();

    // Contention from reset: grants alternate I, D, I, D
    do_reset();
    exp_d = '{1'b0, 1'b1, 1'b0, 1'b1};
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_0100;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h0000_0200;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rr%0d_addr", k), bus.mem_addr, exp_d[k] ? 32'h0000_0200 : 32'h0000_0100);
      for (int w = 0; w < 3; w++) begin
        chk($sformatf("rr%0d_wait%0d", k, w), {bus.mem_req, bus.i_ack, bus.d_ack}, 3'b100);
        tick();
      end
      rd_val        = 32'hA000_0000 + 32'(k);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = rd_val;
      tick();
      chk($sformatf("rr%0d_ack", k), {bus.i_ack, bus.d_ack, bus.err},
          {!exp_d[k], exp_d[k], 1'b0});
      chk($sformatf("rr%0d_rdata", k), exp_d[k] ? bus.d_rdata : bus.i_rdata, rd_val);
      bus.mem_ack = 1'b0;
      tick();
    end
    clear_inputs();
    tick();

    // D read never acked: watchdog expiry
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h0000_0300;
    tick();
    cnt = 0;
    while (bus.mem_req === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("to_req_cycles", 32'(cnt), 32'd64);
    chk("to_ack_err", {bus.i_ack, bus.d_ack, bus.err}, 3'b011);
    chk("to_rdata_zero", bus.d_rdata, 32'h0);
    bus.d_req = 1'b0;
    tick();
    chk("to_err_pulse", {bus.err, bus.busy}, 2'b00);

    // Next request after a timeout is served normally
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h0000_0304;
    tick();
    chk("post_to_req", bus.mem_req, 1'b1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h55AA_55AA;
    tick();
    chk("post_to_ack", {bus.d_ack, bus.err}, 2'b10);
    chk("post_to_rdata", bus.d_rdata, 32'h55AA_55AA);
    clear_inputs();
    tick();

    // mem_ack on the last allowed WAIT cycle counts as success
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_0400;
    tick();
    repeat (63) tick();
    chk("edge_still_wait", {bus.mem_req, bus.i_ack}, 2'b10);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    tick();
    chk("edge_ack_err", {bus.i_ack, bus.err}, 2'b10);
    chk("edge_rdata", bus.i_rdata, 32'hCAFE_F00D);
    clear_inputs();
    tick();

    // Reset in the second WAIT cycle abandons the I read
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_0480;
    tick();
    tick();
    chk("rst_mid_wait", bus.mem_req, 1'b1);
    rst = 1'b1;
    tick();
    chk("rst_mid_state", {bus.mem_req, bus.busy, bus.i_ack}, 3'b000);
    rst         = 1'b0;
    bus.i_req   = 1'b0;
    bus.d_req   = 1'b1;
    bus.d_addr  = 32'h0000_0500;
    tick();
    chk("rst_fresh_d_addr", bus.mem_addr, 32'h0000_0500);
    chk("rst_fresh_d_req", {bus.mem_req, bus.i_ack}, 2'b10);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0BAD_F00D;
    tick();
    chk("rst_fresh_d_ack", {bus.i_ack, bus.d_ack}, 2'b01);
    clear_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
